// File: rtl/snake_frame_scheduler_if.sv
// ============================================================================
// snake_frame_scheduler_if : signals between the frame scheduler, the VGA
// timing, the body RAM and the graphic block. Build option: SCHED_CLEAR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface snake_frame_scheduler_if #(
  parameter int PIX_W = 10
);
  logic [PIX_W-1:0] X;
  logic [PIX_W-1:0] Y;
  logic [3:0]       snake_length;
  logic [3:0]       body_rd_addr;
  logic [6:0]       body_rd_x;
  logic [6:0]       body_rd_y;
  logic [6:0]       snake_body_x;
  logic [6:0]       snake_body_y;
  logic             en_snake_body;
  logic             game_tick;
  logic             load_busy;
`ifdef SCHED_CLEAR_EN
  logic             clear_body;
`endif

  modport master (
    input  X, Y, snake_length, body_rd_x, body_rd_y,
`ifdef SCHED_CLEAR_EN
    output clear_body,
`endif
    output body_rd_addr, snake_body_x, snake_body_y,
    output en_snake_body, game_tick, load_busy
  );

  modport slave (
    output X, Y, snake_length, body_rd_x, body_rd_y,
`ifdef SCHED_CLEAR_EN
    input  clear_body,
`endif
    input  body_rd_addr, snake_body_x, snake_body_y,
    input  en_snake_body, game_tick, load_busy
  );
endinterface

`default_nettype wire

// File: rtl/snake_frame_scheduler.sv
// ============================================================================
// snake_frame_scheduler : vblank body-segment loader plus game_tick divider.
// Build option: SCHED_CLEAR_EN adds a CLEAR state and the clear_body strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module snake_frame_scheduler #(
  parameter int PIX_W       = 10,
  parameter int V_ACTIVE    = 480,
  parameter int MAX_LEN     = 15,
  parameter int TICK_FRAMES = 8
) (
  input  logic                   clock_25,
  input  logic                   reset,
  snake_frame_scheduler_if.master bus
);

  localparam int             FC_W    = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(TICK_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_PUSH     = 3'd2,
    S_TICK     = 3'd3,
    S_WAIT_END = 3'd4
`ifdef SCHED_CLEAR_EN
    , S_CLEAR  = 3'd5
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      len_q, len_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic [3:0]      addr_q, addr_d;
  logic [6:0]      sx_q, sx_d;
  logic [6:0]      sy_q, sy_d;
  logic            en_q, en_d;
  logic            tick_q, tick_d;
  logic            busy_q, busy_d;
`ifdef SCHED_CLEAR_EN
  logic            clr_q, clr_d;
`endif

  logic            w_start;
  logic [3:0]      w_len_clamped;

  assign w_start       = (bus.X == '0) && (bus.Y == PIX_W'(V_ACTIVE));
  assign w_len_clamped = (bus.snake_length > 4'(MAX_LEN)) ? 4'(MAX_LEN) : bus.snake_length;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    fcnt_d  = fcnt_q;
    addr_d  = addr_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          len_d = w_len_clamped;
          idx_d = '0;
`ifdef SCHED_CLEAR_EN
          state_d = S_CLEAR;
`else
          state_d = (w_len_clamped >= 4'd2) ? S_READ : S_TICK;
`endif
        end
      end
`ifdef SCHED_CLEAR_EN
      S_CLEAR:  state_d = (len_q >= 4'd2) ? S_READ : S_TICK;
`endif
      S_READ:   state_d = S_PUSH;
      S_PUSH: begin
        if (idx_q == len_q - 4'd2) begin
          state_d = S_TICK;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_READ;
        end
      end
      S_TICK: begin
        fcnt_d  = (fcnt_q == FC_LAST) ? '0 : fcnt_q + 1'b1;
        state_d = S_WAIT_END;
      end
      S_WAIT_END: begin
        if (bus.Y == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    // The body RAM reads asynchronously from addr_q, so its data is valid while in READ.
    busy_d = (state_d == S_READ) || (state_d == S_PUSH);
    en_d   = (state_d == S_PUSH);
    tick_d = (state_q == S_TICK) && (fcnt_q == FC_LAST);
    if (state_d == S_READ) addr_d = idx_d;
    if (state_d == S_PUSH) begin
      sx_d = bus.body_rd_x;
      sy_d = bus.body_rd_y;
    end
`ifdef SCHED_CLEAR_EN
    clr_d = (state_d == S_CLEAR);
`endif
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      fcnt_q  <= '0;
      addr_q  <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      en_q    <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SCHED_CLEAR_EN
      clr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      fcnt_q  <= fcnt_d;
      addr_q  <= addr_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      en_q    <= en_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
`ifdef SCHED_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  assign bus.body_rd_addr  = addr_q;
  assign bus.snake_body_x  = sx_q;
  assign bus.snake_body_y  = sy_q;
  assign bus.en_snake_body = en_q;
  assign bus.game_tick     = tick_q;
  assign bus.load_busy     = busy_q;
`ifdef SCHED_CLEAR_EN
  assign bus.clear_body    = clr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_snake_frame_scheduler.sv
// ============================================================================
// tb_snake_frame_scheduler : frame-level vectors with an event scoreboard.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_snake_frame_scheduler;

`ifdef SCHED_CLEAR_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif

  typedef struct { int cyc; int a; int b; } ev_t;
  typedef struct { int len; int len2; int chg; int rst_at; int exp_push; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   busy_cnt = 0;
  int   push_cnt = 0;
  int   tick_seen = 0;
  int   fcnt = 0;
  int   tick_base;
  ev_t  push_q[$];
  ev_t  addr_q[$];
  ev_t  tick_q[$];
  ev_t  clr_q[$];
  logic [6:0] ram_x [16];
  logic [6:0] ram_y [16];
  vec_t vecs [8];

  snake_frame_scheduler_if #(.PIX_W(10)) bus ();

  snake_frame_scheduler #(
    .PIX_W(10), .V_ACTIVE(480), .MAX_LEN(15), .TICK_FRAMES(8)
  ) dut (
    .clock_25 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.body_rd_x = ram_x[bus.body_rd_addr];
  assign bus.body_rd_y = ram_y[bus.body_rd_addr];

  task automatic check(input string name, input bit ok, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ev(input string name, input ev_t e, input int a, input int b);
    n_cmp++;
    if (e.cyc != cyc || e.a != a || e.b != b) begin
      n_err++;
      $display("FAIL %s: got cycle %0d (%0d,%0d), expected cycle %0d (%0d,%0d)",
               name, cyc, a, b, e.cyc, e.a, e.b);
    end
  endtask

  task automatic check_zero(input string name);
    int v;
    v = int'({bus.en_snake_body, bus.game_tick, bus.load_busy, bus.body_rd_addr,
              bus.snake_body_x, bus.snake_body_y});
`ifdef SCHED_CLEAR_EN
    v = v | (int'(bus.clear_body) << 21);
`endif
    check(name, v == 0, v, 0);
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (bus.load_busy) busy_cnt++;
      if (bus.en_snake_body) begin
        push_cnt++;
        if (push_q.size() == 0) check("push_unexpected", 1'b0, cyc, -1);
        else begin
          e = push_q.pop_front();
          check_ev("push", e, int'(bus.snake_body_x), int'(bus.snake_body_y));
        end
      end
      if (bus.load_busy && !bus.en_snake_body) begin
        if (addr_q.size() == 0) check("read_unexpected", 1'b0, cyc, -1);
        else begin
          e = addr_q.pop_front();
          check_ev("rd_addr", e, int'(bus.body_rd_addr), 0);
        end
      end
      if (bus.game_tick) begin
        tick_seen++;
        if (tick_q.size() == 0) check("tick_unexpected", 1'b0, cyc, -1);
        else begin
          e = tick_q.pop_front();
          check_ev("game_tick", e, 0, 0);
        end
      end
`ifdef SCHED_CLEAR_EN
      if (bus.clear_body) begin
        if (clr_q.size() == 0) check("clear_unexpected", 1'b0, cyc, -1);
        else begin
          e = clr_q.pop_front();
          check_ev("clear_body", e, 0, 0);
        end
      end
`endif
    end
  endtask

  // One frame: vblank start, optional length change / reset, spurious restart, frame end.
  task automatic run_frame(input vec_t v);
    int t0, cut, n, ln, lo, hi, busy_exp;
    @(posedge clk); #1;
    bus.X = '0;
    bus.Y = 10'd480;
    bus.snake_length = 4'(v.len);
    t0 = cyc;
    busy_cnt = 0;
    push_cnt = 0;
    ln  = (v.len > 15) ? 15 : v.len;
    n   = (ln >= 2) ? ln - 1 : 0;
    cut = (v.rst_at > 0) ? t0 + v.rst_at : t0 + 1000;
`ifdef SCHED_CLEAR_EN
    clr_q.push_back('{t0 + 1, 0, 0});
`endif
    for (int k = 0; k < n; k++) begin
      if (t0 + OFS + 1 + 2*k <= cut) addr_q.push_back('{t0 + OFS + 1 + 2*k, k, 0});
      if (t0 + OFS + 2 + 2*k <= cut)
        push_q.push_back('{t0 + OFS + 2 + 2*k, int'(ram_x[k]), int'(ram_y[k])});
    end
    if (v.rst_at == 0) begin
      if (fcnt == 7) begin
        tick_q.push_back('{t0 + OFS + ((n > 0) ? 2*n + 2 : 2), 0, 0});
        fcnt = 0;
      end else begin
        fcnt++;
      end
    end else begin
      fcnt = 0;
    end
    lo = t0 + OFS + 1;
    hi = t0 + OFS + 2*n;
    if (hi > cut) hi = cut;
    busy_exp = (n > 0 && hi >= lo) ? hi - lo + 1 : 0;

    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      bus.X = 10'(j);
      bus.Y = 10'd481;
      if (j == v.chg) bus.snake_length = 4'(v.len2);
      rst = (j == v.rst_at);
      if (v.rst_at > 0 && j == v.rst_at + 1) check_zero("reset_midload_outputs");
      if (v.rst_at == 0 && j == 35) begin
        bus.X = '0;
        bus.Y = 10'd480;
      end
    end
    @(posedge clk); #1;
    rst   = 1'b0;
    bus.X = 10'd3;
    bus.Y = '0;
    @(posedge clk); #1;
    bus.Y = 10'd1;
    check("push_count", push_cnt == v.exp_push, push_cnt, v.exp_push);
    check("busy_cycles", busy_cnt == busy_exp, busy_cnt, busy_exp);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      ram_x[k] = 7'(8 + k);
      ram_y[k] = (k < 3) ? 7'd8 : 7'(20 + k);
    end
    // {len, len after change, change cycle, reset cycle, expected pushes}
    vecs = '{'{4, 4, 0, 0, 3},
             '{1, 1, 0, 0, 0},
             '{0, 0, 0, 0, 0},
             '{3, 6, 3, 0, 2},
             '{6, 6, 0, 0, 5},
             '{15, 15, 0, 0, 14},
             '{4, 4, 0, 3, 1},
             '{4, 4, 0, 0, 3}};

    bus.X = 10'd5;
    bus.Y = 10'd100;
    bus.snake_length = 4'd4;
    rst = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) begin
      @(posedge clk); #1;
      check_zero("reset_outputs");
    end
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      bus.X = 10'($urandom_range(1, 799));
      bus.Y = 10'($urandom_range(0, 524));
    end
    @(posedge clk); #1;
    bus.Y = 10'd1;
    check("idle_busy", busy_cnt == 0, busy_cnt, 0);
    check_zero("idle_outputs");

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    tick_base = tick_seen;
    for (int f = 0; f < 16; f++) run_frame('{2, 2, 0, 0, 1});
    check("ticks_in_16_frames", tick_seen - tick_base == 2, tick_seen - tick_base, 2);

    repeat (3) @(posedge clk);
    #1;
    check("push_queue_drained", push_q.size() == 0, push_q.size(), 0);
    check("addr_queue_drained", addr_q.size() == 0, addr_q.size(), 0);
    check("tick_queue_drained", tick_q.size() == 0, tick_q.size(), 0);
`ifdef SCHED_CLEAR_EN
    check("clear_queue_drained", clr_q.size() == 0, clr_q.size(), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
